// File: rtl/lap_timer_pkg.sv
// Shared types and field constants for the lap timer.
package lap_timer_pkg;

  typedef enum logic [1:0] {
    STOP    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  localparam int unsigned SEC_MAX = 59;
  localparam int unsigned MIN_MAX = 59;
  localparam int unsigned HOUR_W  = 5;
  localparam int unsigned MIN_W   = 6;
  localparam int unsigned SEC_W   = 6;

endpackage

// File: rtl/lap_timer_cascade_stage.sv
// One digit-group of the time cascade: wraps up at MAX, borrows down from 0,
// saturates preset values above MAX. MAX=0 makes the stage a pass-through
// carry that always holds 0.
module mod_cascade_stage #(
  parameter int unsigned MAX = 59,
  parameter int unsigned W   = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step,
  input  logic         dir,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         carry_out,
  output logic         is_zero
);

  localparam logic [W-1:0] MAXV = W'(MAX);

  logic [W-1:0] r_value;
  logic [W-1:0] w_next;
  logic         w_at_limit;

  assign w_at_limit = dir ? (r_value == '0) : (r_value == MAXV);
  assign carry_out  = step & w_at_limit;
  assign is_zero    = (r_value == '0);
  assign value      = r_value;

  // Next value: saturating preset, else wrap/borrow step.
  always_comb begin
    w_next = r_value;
    if (load) begin
      w_next = (load_val > MAXV) ? MAXV : load_val;
    end else if (step) begin
      if (w_at_limit) w_next = dir ? MAXV : '0;
      else            w_next = dir ? (r_value - 1'b1) : (r_value + 1'b1);
    end
  end

  // Field register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_value <= '0;
    else     r_value <= w_next;
  end

endmodule

// File: rtl/lap_timer.sv
// Lap timer: prescaled hh:mm:ss:frac up/down counter with preset, lap
// capture and expiry/wrap pulses.
module lap_timer
  import lap_timer_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100,
  parameter int unsigned FRAC_MAX = 99,
  parameter int unsigned HOUR_MAX = 23,
  parameter int unsigned FRAC_W   = 7
) (
  input  logic              signal,
  input  logic              clr,
  input  logic              en,
  input  logic              starp,
  input  logic              mode,
  input  logic              load,
  input  logic [HOUR_W-1:0] load_hour,
  input  logic [MIN_W-1:0]  load_minute,
  input  logic [SEC_W-1:0]  load_second,
  input  logic [FRAC_W-1:0] load_frac,
  input  logic              lap,
  output logic [HOUR_W-1:0] hour,
  output logic [MIN_W-1:0]  minute,
  output logic [SEC_W-1:0]  second,
  output logic [FRAC_W-1:0] frac,
  output logic [HOUR_W-1:0] lap_hour,
  output logic [MIN_W-1:0]  lap_minute,
  output logic [SEC_W-1:0]  lap_second,
  output logic [FRAC_W-1:0] lap_frac,
  output logic              lap_valid,
  output logic              running,
  output logic              expired,
  output logic              wrap
);

  localparam int unsigned   PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  state_t      r_state, w_state_nxt;
  logic [PW-1:0] r_presc;
  logic        r_expired, r_wrap, r_lap_valid;
  logic [HOUR_W-1:0] r_lap_hour;
  logic [MIN_W-1:0]  r_lap_minute;
  logic [SEC_W-1:0]  r_lap_second;
  logic [FRAC_W-1:0] r_lap_frac;

  logic w_run, w_tick, w_step, w_load, w_zero, w_unit, w_expire, w_wrap;
  logic w_c_frac, w_c_sec, w_c_min, w_c_hour;
  logic w_z_frac, w_z_sec, w_z_min, w_z_hour;

  assign w_run  = en && (r_state == RUN);
  assign w_tick = w_run && (r_presc == PRESC_LAST);
  assign w_load = en && load && (r_state != RUN);
  assign w_zero = w_z_frac && w_z_sec && w_z_min && w_z_hour;
  // Count is one step above zero, so the next down step lands on zero.
  assign w_unit = w_z_hour && w_z_min &&
                  ((FRAC_MAX == 0) ? (second == SEC_W'(1))
                                   : (w_z_sec && (frac == FRAC_W'(1))));
  // A down step from zero is suppressed so the count never underflows.
  assign w_step = w_tick && !(mode && w_zero);
  assign w_wrap = w_step && !mode && w_c_hour;

  mod_cascade_stage #(.MAX(FRAC_MAX), .W(FRAC_W)) u_frac (
    .clk(signal), .rst(clr), .step(w_step), .dir(mode), .load(w_load),
    .load_val(load_frac), .value(frac), .carry_out(w_c_frac), .is_zero(w_z_frac));

  mod_cascade_stage #(.MAX(SEC_MAX), .W(SEC_W)) u_sec (
    .clk(signal), .rst(clr), .step(w_c_frac), .dir(mode), .load(w_load),
    .load_val(load_second), .value(second), .carry_out(w_c_sec), .is_zero(w_z_sec));

  mod_cascade_stage #(.MAX(MIN_MAX), .W(MIN_W)) u_min (
    .clk(signal), .rst(clr), .step(w_c_sec), .dir(mode), .load(w_load),
    .load_val(load_minute), .value(minute), .carry_out(w_c_min), .is_zero(w_z_min));

  mod_cascade_stage #(.MAX(HOUR_MAX), .W(HOUR_W)) u_hour (
    .clk(signal), .rst(clr), .step(w_c_min), .dir(mode), .load(w_load),
    .load_val(load_hour), .value(hour), .carry_out(w_c_hour), .is_zero(w_z_hour));

  // Next-state and expiry pulse decode.
  always_comb begin
    w_state_nxt = r_state;
    w_expire    = 1'b0;
    if (en) begin
      case (r_state)
        STOP: begin
          // A preset in the same cycle as start wins; start is seen next cycle.
          if (!w_load && starp) begin
            if (mode && w_zero) begin
              w_state_nxt = EXPIRED;
              w_expire    = 1'b1;
            end else begin
              w_state_nxt = RUN;
            end
          end
        end
        RUN: begin
          if (w_tick && mode && (w_zero || w_unit)) begin
            w_state_nxt = EXPIRED;
            w_expire    = 1'b1;
          end else if (!starp) begin
            w_state_nxt = STOP;
          end
        end
        EXPIRED: begin
          if (w_load || !starp) w_state_nxt = STOP;
        end
        default: w_state_nxt = STOP;
      endcase
    end
  end

  // State register.
  always_ff @(posedge signal or posedge clr) begin
    if (clr) r_state <= STOP;
    else     r_state <= w_state_nxt;
  end

  // Prescaler: runs only in RUN, holds otherwise, cleared by preset.
  always_ff @(posedge signal or posedge clr) begin
    if (clr)         r_presc <= '0;
    else if (w_load) r_presc <= '0;
    else if (w_run)  r_presc <= w_tick ? '0 : (r_presc + 1'b1);
  end

  // Registered one-cycle pulses.
  always_ff @(posedge signal or posedge clr) begin
    if (clr) begin
      r_expired <= 1'b0;
      r_wrap    <= 1'b0;
    end else begin
      r_expired <= w_expire;
      r_wrap    <= w_wrap;
    end
  end

  // Lap capture of the pre-edge count; a lap beats a simultaneous preset clear.
  always_ff @(posedge signal or posedge clr) begin
    if (clr) begin
      r_lap_hour   <= '0;
      r_lap_minute <= '0;
      r_lap_second <= '0;
      r_lap_frac   <= '0;
      r_lap_valid  <= 1'b0;
    end else if (en && lap) begin
      r_lap_hour   <= hour;
      r_lap_minute <= minute;
      r_lap_second <= second;
      r_lap_frac   <= frac;
      r_lap_valid  <= 1'b1;
    end else if (w_load) begin
      r_lap_valid  <= 1'b0;
    end
  end

  assign lap_hour   = r_lap_hour;
  assign lap_minute = r_lap_minute;
  assign lap_second = r_lap_second;
  assign lap_frac   = r_lap_frac;
  assign lap_valid  = r_lap_valid;
  assign running    = (r_state == RUN);
  assign expired    = r_expired;
  assign wrap       = r_wrap;

endmodule

// File: tb/tb_lap_timer.sv
// Scoreboard bench for lap_timer (TICK_DIV=2, FRAC_MAX=9).
module tb_lap_timer;

  localparam int FW = 4;

  logic          clk = 1'b0;
  logic          clr, en, starp, mode, load, lap;
  logic [4:0]    load_hour;
  logic [5:0]    load_minute, load_second;
  logic [FW-1:0] load_frac;
  logic [4:0]    hour, lap_hour;
  logic [5:0]    minute, second, lap_minute, lap_second;
  logic [FW-1:0] frac, lap_frac;
  logic          lap_valid, running, expired, wrap;

  lap_timer #(.TICK_DIV(2), .FRAC_MAX(9), .HOUR_MAX(23), .FRAC_W(FW)) dut (
    .signal(clk), .clr(clr), .en(en), .starp(starp), .mode(mode), .load(load),
    .load_hour(load_hour), .load_minute(load_minute), .load_second(load_second),
    .load_frac(load_frac), .lap(lap),
    .hour(hour), .minute(minute), .second(second), .frac(frac),
    .lap_hour(lap_hour), .lap_minute(lap_minute), .lap_second(lap_second),
    .lap_frac(lap_frac), .lap_valid(lap_valid), .running(running),
    .expired(expired), .wrap(wrap));

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string         tag;
    int unsigned   cyc;
    int            kind;   // 0 count, 1 lap, 2 flags
    logic [4:0]    h;
    logic [5:0]    m, s;
    logic [FW-1:0] f;
    logic          lv, run, expd, wrp;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic push_cnt(input string tag, input int unsigned at,
                          input int h, input int m, input int s, input int f);
    exp_t e;
    e.tag = tag; e.cyc = at; e.kind = 0;
    e.h = 5'(h); e.m = 6'(m); e.s = 6'(s); e.f = FW'(f);
    sb.push_back(e);
  endtask

  task automatic push_lap(input string tag, input int unsigned at,
                          input int h, input int m, input int s, input int f,
                          input logic lv);
    exp_t e;
    e.tag = tag; e.cyc = at; e.kind = 1;
    e.h = 5'(h); e.m = 6'(m); e.s = 6'(s); e.f = FW'(f); e.lv = lv;
    sb.push_back(e);
  endtask

  task automatic push_flg(input string tag, input int unsigned at,
                          input logic run, input logic expd, input logic wrp);
    exp_t e;
    e.tag = tag; e.cyc = at; e.kind = 2;
    e.run = run; e.expd = expd; e.wrp = wrp;
    sb.push_back(e);
  endtask

  task automatic check_entry(input exp_t e);
    n_cmp++;
    case (e.kind)
      0: if ({hour, minute, second, frac} !== {e.h, e.m, e.s, e.f}) begin
           n_err++;
           $display("FAIL %s count: got %0d:%0d:%0d:%0d required %0d:%0d:%0d:%0d",
                    e.tag, hour, minute, second, frac, e.h, e.m, e.s, e.f);
         end
      1: if ({lap_hour, lap_minute, lap_second, lap_frac, lap_valid} !==
             {e.h, e.m, e.s, e.f, e.lv}) begin
           n_err++;
           $display("FAIL %s lap: got %0d:%0d:%0d:%0d v=%0b required %0d:%0d:%0d:%0d v=%0b",
                    e.tag, lap_hour, lap_minute, lap_second, lap_frac, lap_valid,
                    e.h, e.m, e.s, e.f, e.lv);
         end
      default: if ({running, expired, wrap} !== {e.run, e.expd, e.wrp}) begin
           n_err++;
           $display("FAIL %s flags(run,exp,wrap): got %b%b%b required %b%b%b",
                    e.tag, running, expired, wrap, e.run, e.expd, e.wrp);
         end
    endcase
  endtask

  // Monitor: on each falling edge, retire every expectation due this cycle.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        check_entry(sb[i]);
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        n_cmp++;
        n_err++;
        $display("FAIL %s missed: due cycle %0d, now %0d", sb[i].tag, sb[i].cyc, cyc);
        sb.delete(i);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int unsigned c;

  initial begin
    clr = 1'b1; en = 1'b0; starp = 1'b0; mode = 1'b0; load = 1'b0; lap = 1'b0;
    load_hour = '0; load_minute = '0; load_second = '0; load_frac = '0;
    cycles(2);

    // Reset state.
    push_cnt("rst_cnt", cyc, 0, 0, 0, 0);
    push_lap("rst_lap", cyc, 0, 0, 0, 0, 1'b0);
    push_flg("rst_flg", cyc, 1'b0, 1'b0, 1'b0);
    cycles(1);
    clr = 1'b0;
    cycles(1);

    // Up count: first step two RUN edges after entry, 20 steps in 40 RUN edges.
    c = cyc; en = 1'b1; starp = 1'b1; mode = 1'b0;
    push_flg("s1_run", c + 1, 1'b1, 1'b0, 1'b0);
    push_cnt("s1_c1", c + 2, 0, 0, 0, 0);
    push_cnt("s1_first", c + 3, 0, 0, 0, 1);
    push_cnt("s1_40", c + 41, 0, 0, 2, 0);
    push_flg("s1_flg", c + 41, 1'b1, 1'b0, 1'b0);
    cycles(41);
    starp = 1'b0;
    cycles(1);

    // Up wrap from 23:59:59:9.
    c = cyc; load = 1'b1;
    load_hour = 5'd23; load_minute = 6'd59; load_second = 6'd59; load_frac = 4'd9;
    push_cnt("s2_load", c + 1, 23, 59, 59, 9);
    cycles(1);
    load = 1'b0; starp = 1'b1;
    push_cnt("s2_pre", c + 3, 23, 59, 59, 9);
    push_flg("s2_pre_f", c + 3, 1'b1, 1'b0, 1'b0);
    push_cnt("s2_wrap", c + 4, 0, 0, 0, 0);
    push_flg("s2_wrap_f", c + 4, 1'b1, 1'b0, 1'b1);
    push_flg("s2_wrap_end", c + 5, 1'b1, 1'b0, 1'b0);
    cycles(4);
    starp = 1'b0;
    cycles(1);

    // Countdown from 0:0:1:0 to expiry, hold at zero, then zero-start expiry.
    c = cyc; mode = 1'b1; load = 1'b1;
    load_hour = 5'd0; load_minute = 6'd0; load_second = 6'd1; load_frac = 4'd0;
    cycles(1);
    load = 1'b0; starp = 1'b1;
    push_cnt("s3_9", c + 4, 0, 0, 0, 9);
    push_cnt("s3_one", c + 21, 0, 0, 0, 1);
    push_flg("s3_pre", c + 21, 1'b1, 1'b0, 1'b0);
    push_cnt("s3_zero", c + 22, 0, 0, 0, 0);
    push_flg("s3_exp", c + 22, 1'b0, 1'b1, 1'b0);
    push_flg("s3_exp_end", c + 23, 1'b0, 1'b0, 1'b0);
    push_cnt("s3_hold", c + 26, 0, 0, 0, 0);
    cycles(25);
    starp = 1'b0;
    cycles(1);
    starp = 1'b1;
    push_flg("s3_zstart", c + 28, 1'b0, 1'b1, 1'b0);
    push_flg("s3_zs_end", c + 29, 1'b0, 1'b0, 1'b0);
    cycles(2);
    starp = 1'b0;
    cycles(1);

    // Lap + load collision, then load in RUN ignored.
    c = cyc; mode = 1'b0; load = 1'b1;
    load_hour = 5'd0; load_minute = 6'd0; load_second = 6'd3; load_frac = 4'd4;
    cycles(1);
    load = 1'b0; starp = 1'b1;
    push_flg("s4_run", c + 2, 1'b1, 1'b0, 1'b0);
    cycles(1);
    starp = 1'b0;
    cycles(1);
    lap = 1'b1; load = 1'b1;
    load_hour = 5'd0; load_minute = 6'd1; load_second = 6'd0; load_frac = 4'd0;
    push_lap("s4_lap", c + 4, 0, 0, 3, 4, 1'b1);
    push_cnt("s4_load", c + 4, 0, 1, 0, 0);
    cycles(1);
    lap = 1'b0; load = 1'b0; starp = 1'b1;
    cycles(1);
    load = 1'b1;
    load_minute = 6'd0;
    push_cnt("s4_runload", c + 6, 0, 1, 0, 0);
    push_lap("s4_lv_keep", c + 6, 0, 0, 3, 4, 1'b1);
    cycles(1);
    load = 1'b0;
    push_cnt("s4_tick", c + 7, 0, 1, 0, 1);
    cycles(1);
    starp = 1'b0;
    cycles(1);

    // Saturating preset, then en=0 freeze.
    c = cyc; load = 1'b1;
    load_hour = 5'd31; load_minute = 6'd63; load_second = 6'd5; load_frac = 4'd15;
    push_cnt("s5_sat", c + 1, 23, 59, 5, 9);
    push_lap("s5_lv_clr", c + 1, 0, 0, 3, 4, 1'b0);
    cycles(1);
    en = 1'b0; starp = 1'b1; lap = 1'b1;
    load_hour = 5'd1; load_minute = 6'd1; load_second = 6'd1; load_frac = 4'd1;
    cycles(10);
    push_cnt("s5_frz", c + 11, 23, 59, 5, 9);
    push_flg("s5_frz_f", c + 11, 1'b0, 1'b0, 1'b0);
    push_lap("s5_frz_l", c + 11, 0, 0, 3, 4, 1'b0);
    cycles(1);
    lap = 1'b0; load = 1'b0;

    // Run with lap, then asynchronous clear between edges.
    c = cyc; en = 1'b1; starp = 1'b1; mode = 1'b0;
    push_cnt("s6_t1", c + 3, 23, 59, 6, 0);
    cycles(3);
    lap = 1'b1;
    push_lap("s6_lap", c + 4, 23, 59, 6, 0, 1'b1);
    cycles(1);
    lap = 1'b0;
    push_cnt("s6_t2", c + 5, 23, 59, 6, 1);
    cycles(2);
    #1;
    clr = 1'b1;
    push_cnt("s6_clr_cnt", cyc, 0, 0, 0, 0);
    push_lap("s6_clr_lap", cyc, 0, 0, 0, 0, 1'b0);
    push_flg("s6_clr_flg", cyc, 1'b0, 1'b0, 1'b0);
    cycles(2);
    mode = 1'b1;
    clr = 1'b0;

    // Down start at zero expires immediately.
    c = cyc;
    push_flg("s6_zstart", c + 1, 1'b0, 1'b1, 1'b0);
    push_flg("s6_zs_end", c + 2, 1'b0, 1'b0, 1'b0);
    cycles(2);
    starp = 1'b0;

    for (int k = 0; k < 20 && sb.size() > 0; k++) cycles(1);
    if (sb.size() > 0) begin
      foreach (sb[i]) begin
        n_cmp++;
        n_err++;
        $display("FAIL %s timeout: never compared (due cycle %0d)", sb[i].tag, sb[i].cyc);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lap_timer.md
Name: lap_timer

Overview:
Parametrised successor to the hour/minute/second watch counter. It adds a configurable sub-second field, an internal tick prescaler, up/down (stopwatch/countdown) modes, preset load, lap capture and expiry/wrap pulses. It sits between the board clock domain and the 7-segment display mux, and feeds the buzzer logic through `expired`.

Parameters:
TICK_DIV, 100, `signal` cycles per sub-second step (≥1; 1 = step every enabled cycle)
FRAC_MAX, 99, max value of sub-second field (99 = centiseconds; 0 disables the field)
HOUR_MAX, 23, max hour value before wrap
FRAC_W, 7, width of sub-second field (≥ clog2(FRAC_MAX+1), min 1)

Ports:
signal  in  1  clock, rising edge
clr  in  1  asynchronous active-high reset
en  in  1  global enable; when low, state, prescaler and counts frozen
starp  in  1  run level: 1 = count, 0 = pause
mode  in  1  0 = count up, 1 = count down
load  in  1  preset strobe, honoured only when not RUN
load_hour / load_minute / load_second / load_frac  in  5/6/6/FRAC_W  preset values
lap  in  1  lap capture strobe (single-cycle)
hour / minute / second / frac  out  5/6/6/FRAC_W  live count
lap_hour / lap_minute / lap_second / lap_frac  out  5/6/6/FRAC_W  captured count
lap_valid  out  1  lap registers hold a capture
running  out  1  state == RUN
expired  out  1  one-cycle pulse, countdown reached zero
wrap  out  1  one-cycle pulse, up-count wrapped past HOUR_MAX:59:59:FRAC_MAX

Behaviour:
- clr asserted (async): all counts, lap regs and prescaler 0; lap_valid, expired, wrap 0; state STOP. Mid-operation clr aborts immediately; no pulses issued.
- States: STOP, RUN, EXPIRED. Transitions evaluated only when en=1:
  - STOP→RUN: starp=1 and not (mode=1 and count all-zero).
  - STOP→EXPIRED: starp=1, mode=1, count all-zero. expired pulses on this edge.
  - RUN→STOP: starp=0.
  - RUN→EXPIRED: down-tick yields all-zero. expired pulses on the same edge the count becomes zero.
  - EXPIRED→STOP: starp=0.
- Prescaler: counts 0..TICK_DIV-1 only in RUN with en=1. tick = (prescaler==TICK_DIV-1); it then resets to 0. The prescaler holds its value in STOP and is cleared by load.
- First step occurs TICK_DIV enabled RUN cycles after entering RUN from a fresh prescaler.
- Up tick: cascaded increment frac→second→minute→hour, each wrapping at its max (frac at FRAC_MAX, second/minute at 59, hour at HOUR_MAX). The full wrap to 0:0:0:0 asserts wrap for 1 cycle; counting continues.
- Down tick: cascaded decrement with borrow; a field at 0 borrows and reloads to its max. Reaching all-zero ends counting (no underflow).
- mode may change in RUN; it takes effect on the next tick; prescaler is unaffected.
- load (en=1, state≠RUN): counts ← load_* values. Any field above its max saturates to its max. Prescaler cleared; lap_valid cleared. In EXPIRED, load returns the state to STOP. load in RUN is ignored.
- lap (en=1, any state): lap_* ← live count as it was before this edge's update. lap_valid ← 1. With simultaneous load, lap captures the pre-load value and lap_valid ends 1.
- en=0: all inputs ignored except clr; expired/wrap forced 0.
- FRAC_MAX=0: frac held at 0; the cascade starts at second.
- All outputs registered; count latency is 1 cycle from tick.

Decomposition:
- lap_timer_pkg: state enum (STOP=2'd0, RUN=2'd1, EXPIRED=2'd2), SEC_MAX=59, MIN_MAX=59, field width constants.
- Sub-module mod_cascade_stage (params MAX, W): inputs step, dir, load, load_val. Outputs value, carry_out (wrap up or borrow down), is_zero. Instantiated 4×; lap_timer holds the FSM, prescaler, lap registers and pulses.

Test Plan:
- Bench parameters for all scenarios: TICK_DIV=2, FRAC_MAX=9.
- Reset/up count: clr, then en=1, starp=1, mode=0 for 40 cycles → frac=0, second=2. After TICK_DIV-cycle steps, running=1, expired=0.
- Up wrap: load 23:59:59:9, starp=1 → after 2 enabled cycles count=0:0:0:0 and wrap pulses exactly 1 cycle.
- Countdown expiry: load 0:0:1:0, mode=1, starp=1 → after 20 cycles count=0:0:0:0, expired 1-cycle pulse, state EXPIRED, count stays 0. starp=0 → STOP.
- Lap + load collision: running at 0:0:3:4, assert lap and (after starp=0) load 0:1:0:0 same cycle → lap_*=0:0:3:4, lap_valid=1, count=0:1:0:0. Load in RUN → ignored.
- Saturation/en freeze: load minute=63, frac=15 → minute=59, frac=9. en=0 with starp=1 for 10 cycles → no change.
- Async clr mid-run: clr asserted between edges → all outputs 0 before next edge. Down start at zero → immediate EXPIRED with expired pulse.
